// File: rtl/cordic_arb_pkg.sv
// ---------------------------------------------------------------------------
// cordic_arb_pkg
//
// Shared definitions for the CORDIC magnitude arbiter:
//   arb_state_t        - arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   NOMINAL_LAT_OFFSET - engine latency beyond its iteration count
//   DEFAULT_TIMEOUT    - default WAIT-state cycle limit
//   nominal_latency()  - engine latency (from start pulse) for a given ITER
// ---------------------------------------------------------------------------
package cordic_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam int NOMINAL_LAT_OFFSET = 3;
    localparam int DEFAULT_TIMEOUT    = 64;

    function automatic int nominal_latency(input int iter);
        return iter + NOMINAL_LAT_OFFSET;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational round-robin picker. The search starts at ptr+1 and
// wraps modulo N_REQ, so the last winner has the lowest priority.
//
// Ports:
//   req       in  N_REQ  request vector
//   ptr       in  ID_W   index of the previous winner
//   grant     out N_REQ  one-hot grant (zero when no request)
//   grant_idx out ID_W   encoded index of the grant (0 when no request)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);

    logic            found;
    logic [ID_W-1:0] cand;

    // Walk every requester once, starting just after the pointer; the
    // first active one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/cordic_mag_arbiter.sv
// ---------------------------------------------------------------------------
// cordic_mag_arbiter
//
// Shares one sequential CORDIC magnitude engine among N_REQ requesters.
// Requests are granted round-robin, one job in flight at a time; the
// engine's single-cycle result pulse is captured and returned, tagged with
// the requester ID, over a valid/ready response port.
//
// Optional feature (macro CORDIC_ARB_TIMEOUT_EN): a WAIT-state watchdog.
// After TIMEOUT_CYC cycles without a result the engine is reset for one
// cycle and a substitute response (mag=0, err=1) is returned. Without the
// macro no counter is built and resp_err is constant 0.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (req_ready one-hot or 0)
//   req_x/req_y           packed signed operands, slice i*DATA_WIDTH
//   resp_valid/resp_ready response handshake
//   resp_id/resp_mag      owner index and magnitude of the result
//   resp_err              result is a timeout substitute
//   eng_rst_n             active-low engine reset
//   eng_valid_in          engine start pulse
//   eng_x/eng_y           operands held for the engine
//   eng_valid_out/eng_mag engine result pulse and value
//   busy                  FSM is not in IDLE
// ---------------------------------------------------------------------------
module cordic_mag_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ID_W        = $clog2(N_REQ),
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_x,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_y,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [ID_W-1:0]             resp_id,
    output logic [DATA_WIDTH-1:0]       resp_mag,
    output logic                        resp_err,
    output logic                        eng_rst_n,
    output logic                        eng_valid_in,
    output logic [DATA_WIDTH-1:0]       eng_x,
    output logic [DATA_WIDTH-1:0]       eng_y,
    input  logic                        eng_valid_out,
    input  logic [DATA_WIDTH-1:0]       eng_mag,
    output logic                        busy
);

    arb_state_t            state_q, state_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [DATA_WIDTH-1:0] eng_x_q, eng_x_d;
    logic [DATA_WIDTH-1:0] eng_y_q, eng_y_d;
    logic [DATA_WIDTH-1:0] mag_q, mag_d;
    logic                  eng_valid_in_q, eng_valid_in_d;
    logic                  resp_valid_q, resp_valid_d;
    logic                  timeout_kill;

    logic [N_REQ-1:0]      grant;
    logic [ID_W-1:0]       grant_idx;
    logic [DATA_WIDTH-1:0] x_arr [N_REQ];
    logic [DATA_WIDTH-1:0] y_arr [N_REQ];

    // Unpack the operand buses so the granted slice is a plain array read.
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign x_arr[i] = req_x[i*DATA_WIDTH +: DATA_WIDTH];
        assign y_arr[i] = req_y[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

`ifdef CORDIC_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;

    // A real result in the same cycle as the limit wins over the timeout.
    assign timeout_kill = (state_q == WAIT) && !eng_valid_out &&
                          (tmo_cnt_q == TMO_W'(TIMEOUT_CYC));
    assign resp_err     = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign timeout_kill       = 1'b0;
    assign resp_err           = 1'b0;
`endif

    // The engine shares our reset and is also killed by a timeout, which
    // discards whatever job it was holding.
    assign eng_rst_n    = ~(rst | timeout_kill);

    // Grants are only offered in IDLE; elsewhere req_valid is ignored.
    assign req_ready    = (state_q == IDLE) ? grant : '0;
    assign busy         = (state_q != IDLE);
    assign eng_valid_in = eng_valid_in_q;
    assign eng_x        = eng_x_q;
    assign eng_y        = eng_y_q;
    assign resp_valid   = resp_valid_q;
    assign resp_id      = id_q;
    assign resp_mag     = mag_q;

    // Next-state logic for the whole job sequence. eng_valid_in_d is only
    // raised on the grant, so the start pulse lines up with ISSUE.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        id_d           = id_q;
        eng_x_d        = eng_x_q;
        eng_y_d        = eng_y_q;
        mag_d          = mag_q;
        eng_valid_in_d = 1'b0;
        resp_valid_d   = resp_valid_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
        err_d          = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    eng_x_d        = x_arr[grant_idx];
                    eng_y_d        = y_arr[grant_idx];
                    id_d           = grant_idx;
                    ptr_d          = grant_idx;
                    eng_valid_in_d = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (eng_valid_out) begin
                    mag_d        = eng_mag;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
`ifdef CORDIC_ARB_TIMEOUT_EN
                    err_d        = 1'b0;
`endif
                end else if (timeout_kill) begin
                    mag_d        = '0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
`ifdef CORDIC_ARB_TIMEOUT_EN
                    err_d        = 1'b1;
`endif
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef CORDIC_ARB_TIMEOUT_EN
    // Counts cycles spent in WAIT; cleared whenever WAIT is left.
    always_comb begin
        tmo_cnt_d = '0;
        if (state_q == WAIT && state_d == WAIT) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end
`endif

    // State and output registers. The pointer resets to the last index so
    // requester 0 has first priority after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            ptr_q          <= ID_W'(N_REQ - 1);
            id_q           <= '0;
            eng_x_q        <= '0;
            eng_y_q        <= '0;
            mag_q          <= '0;
            eng_valid_in_q <= 1'b0;
            resp_valid_q   <= 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
            tmo_cnt_q      <= '0;
            err_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            id_q           <= id_d;
            eng_x_q        <= eng_x_d;
            eng_y_q        <= eng_y_d;
            mag_q          <= mag_d;
            eng_valid_in_q <= eng_valid_in_d;
            resp_valid_q   <= resp_valid_d;
`ifdef CORDIC_ARB_TIMEOUT_EN
            tmo_cnt_q      <= tmo_cnt_d;
            err_q          <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_cordic_mag_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cordic_mag_arbiter
//
// Bench for cordic_mag_arbiter with a behavioural engine model (fixed
// latency ITER+3, exact rounded magnitude, optional mute). Expected
// responses are queued when a grant is expected and popped when the
// arbiter presents a response. The timeout scenario is built only with
// CORDIC_ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
module tb_cordic_mag_arbiter;
    import cordic_arb_pkg::*;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int IDW  = 2;
    localparam int ITER = 16;
    localparam int ENG_LAT = nominal_latency(ITER);

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  mag;
        logic           err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*DW-1:0]  req_x;
    logic [N*DW-1:0]  req_y;
    logic             resp_valid;
    logic             resp_ready = 1'b1;
    logic [IDW-1:0]   resp_id;
    logic [DW-1:0]    resp_mag;
    logic             resp_err;
    logic             eng_rst_n;
    logic             eng_valid_in;
    logic [DW-1:0]    eng_x;
    logic [DW-1:0]    eng_y;
    logic             eng_valid_out = 1'b0;
    logic [DW-1:0]    eng_mag = '0;
    logic             busy;

    logic signed [DW-1:0] op_x [N];
    logic signed [DW-1:0] op_y [N];

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   exp_ptr = N - 1;

    int   eng_cnt = 0;
    bit   eng_busy = 1'b0;
    bit   eng_mute = 1'b0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign req_x[i*DW +: DW] = op_x[i];
        assign req_y[i*DW +: DW] = op_y[i];
    end

    cordic_mag_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .ID_W       (IDW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_y         (req_y),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_mag      (resp_mag),
        .resp_err      (resp_err),
        .eng_rst_n     (eng_rst_n),
        .eng_valid_in  (eng_valid_in),
        .eng_x         (eng_x),
        .eng_y         (eng_y),
        .eng_valid_out (eng_valid_out),
        .eng_mag       (eng_mag),
        .busy          (busy)
    );

    function automatic int mag_of(input logic signed [DW-1:0] x, input logic signed [DW-1:0] y);
        real r;
        r = $sqrt($itor(x) * $itor(x) + $itor(y) * $itor(y));
        return $rtoi(r + 0.5);
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (p + k) % N;
            if (v[j]) return j;
        end
        return 0;
    endfunction

    // Engine model: result pulse ENG_LAT cycles after the start-pulse cycle.
    always @(posedge clk) begin
        if (!eng_rst_n) begin
            eng_busy      <= 1'b0;
            eng_cnt       <= 0;
            eng_valid_out <= 1'b0;
        end else begin
            eng_valid_out <= 1'b0;
            if (eng_valid_in) begin
                eng_busy <= !eng_mute;
                eng_cnt  <= ENG_LAT - 1;
                eng_mag  <= 16'(mag_of(eng_x, eng_y));
            end else if (eng_busy) begin
                if (eng_cnt == 1) begin
                    eng_valid_out <= 1'b1;
                    eng_busy      <= 1'b0;
                end
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        #1;
        while (req_ready == '0 && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (!resp_valid && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic push_exp(input int id);
        exp_t e;
        e.id  = IDW'(id);
        e.mag = 16'(mag_of(op_x[id], op_y[id]));
        e.err = 1'b0;
        sb.push_back(e);
        exp_ptr = id;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = '0;
        tick();
        tick();
        tests_run++;
        if (eng_rst_n !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_eng_rst_n: got %b want 0", eng_rst_n);
        end
        tests_run++;
        if ({busy, resp_valid, resp_id, resp_mag, resp_err, eng_valid_in, eng_x, eng_y, req_ready} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: busy=%b rv=%b id=%0d mag=%h err=%b ev=%b x=%h y=%h rdy=%b want all 0",
                     busy, resp_valid, resp_id, resp_mag, resp_err, eng_valid_in, eng_x, eng_y, req_ready);
        end
        rst = 1'b0;
        exp_ptr = N - 1;
        #1;
        tests_run++;
        if (eng_rst_n !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: eng_rst_n got %b want 1", eng_rst_n);
        end
    endtask

    task automatic test_single_job;
        int c1, c2;
        exp_t e;
        op_x[2] = 16'sh0300;
        op_y[2] = 16'sh0400;
        resp_ready = 1'b1;
        req_valid = 4'b0100;
        wait_grant(c1);
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL single_grant: got %b want 0100", req_ready);
        end
        push_exp(2);
        tick();
        req_valid = '0;
        wait_resp(c2);
        tests_run++;
        if (c2 + 1 != 21) begin
            tests_failed++;
            $display("[TB] FAIL single_latency: got %0d want 21", c2 + 1);
        end
        e = sb.pop_front();
        tests_run++;
        if (resp_id !== e.id || resp_mag !== e.mag || resp_err !== e.err) begin
            tests_failed++;
            $display("[TB] FAIL single_resp: id=%0d mag=%h err=%b want id=%0d mag=%h err=%b",
                     resp_id, resp_mag, resp_err, e.id, e.mag, e.err);
        end
        tests_run++;
        if (resp_mag < 16'h04FE || resp_mag > 16'h0502) begin
            tests_failed++;
            $display("[TB] FAIL single_mag_range: got %h want 0500+-2", resp_mag);
        end
        tick();
        tests_run++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_done: rv=%b busy=%b want 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_negative;
        int c;
        exp_t e;
        op_x[2] = -16'sh0300;
        op_y[2] = 16'sh0400;
        req_valid = 4'b0100;
        wait_grant(c);
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL neg_grant: got %b want 0100", req_ready);
        end
        push_exp(2);
        tick();
        req_valid = '0;
        tests_run++;
        if (eng_valid_in !== 1'b1 || eng_x !== 16'hFD00 || eng_y !== 16'h0400) begin
            tests_failed++;
            $display("[TB] FAIL neg_issue: ev=%b x=%h y=%h want 1 fd00 0400", eng_valid_in, eng_x, eng_y);
        end
        tick();
        tests_run++;
        if (eng_valid_in !== 1'b0 || eng_x !== 16'hFD00) begin
            tests_failed++;
            $display("[TB] FAIL neg_wait: ev=%b x=%h want 0 fd00", eng_valid_in, eng_x);
        end
        wait_resp(c);
        e = sb.pop_front();
        tests_run++;
        if (resp_valid !== 1'b1 || resp_id !== e.id || resp_mag !== e.mag) begin
            tests_failed++;
            $display("[TB] FAIL neg_resp: rv=%b id=%0d mag=%h want 1 %0d %h", resp_valid, resp_id, resp_mag, e.id, e.mag);
        end
        tick();
    endtask

    task automatic test_round_robin;
        int order [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 1, 3, 1, 3};
        int c;
        exp_t e;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ptr = N - 1;
        for (int i = 0; i < N; i++) begin
            op_x[i] = 16'(100 * (i + 1));
            op_y[i] = 16'(-37 * (i + 2));
        end
        for (int j = 0; j < 12; j++) begin
            req_valid = (j < 8) ? 4'b1111 : 4'b1010;
            wait_grant(c);
            tests_run++;
            if (req_ready !== 4'(1 << order[j]) || rr_pick(req_valid, exp_ptr) != order[j]) begin
                tests_failed++;
                $display("[TB] FAIL rr_grant[%0d]: got %b want %b", j, req_ready, 4'(1 << order[j]));
            end
            push_exp(order[j]);
            tick();
            wait_resp(c);
            e = sb.pop_front();
            tests_run++;
            if (resp_valid !== 1'b1 || resp_id !== e.id || resp_mag !== e.mag) begin
                tests_failed++;
                $display("[TB] FAIL rr_resp[%0d]: rv=%b id=%0d mag=%h want 1 %0d %h",
                         j, resp_valid, resp_id, resp_mag, e.id, e.mag);
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure;
        int c;
        int bad;
        exp_t e;
        resp_ready = 1'b0;
        req_valid = 4'b0001;
        wait_grant(c);
        tests_run++;
        if (req_ready !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL bp_grant0: got %b want 0001", req_ready);
        end
        push_exp(0);
        tick();
        req_valid = 4'b0010;
        wait_resp(c);
        e = sb.pop_front();
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (resp_valid !== 1'b1 || resp_id !== e.id || resp_mag !== e.mag || req_ready !== '0) bad++;
            tick();
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("[TB] FAIL bp_hold: %0d unstable cycles, want 0 (last rv=%b id=%0d mag=%h rdy=%b)",
                     bad, resp_valid, resp_id, resp_mag, req_ready);
        end
        resp_ready = 1'b1;
        tick();
        tests_run++;
        if (resp_valid !== 1'b0 || req_ready !== 4'b0010) begin
            tests_failed++;
            $display("[TB] FAIL bp_next_grant: rv=%b rdy=%b want 0 0010", resp_valid, req_ready);
        end
        push_exp(1);
        tick();
        req_valid = '0;
        wait_resp(c);
        e = sb.pop_front();
        tests_run++;
        if (resp_valid !== 1'b1 || resp_id !== e.id || resp_mag !== e.mag) begin
            tests_failed++;
            $display("[TB] FAIL bp_resp1: rv=%b id=%0d mag=%h want 1 %0d %h", resp_valid, resp_id, resp_mag, e.id, e.mag);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait;
        int c;
        int stray;
        exp_t e;
        req_valid = 4'b0100;
        wait_grant(c);
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL rmw_grant: got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        tests_run++;
        if (eng_rst_n !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rmw_eng_rst: got %b want 0", eng_rst_n);
        end
        tick();
        rst = 1'b0;
        exp_ptr = N - 1;
        tests_run++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rmw_idle: busy=%b rv=%b want 0 0", busy, resp_valid);
        end
        stray = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (resp_valid !== 1'b0) stray++;
        end
        tests_run++;
        if (stray != 0) begin
            tests_failed++;
            $display("[TB] FAIL rmw_stray: %0d response cycles, want 0", stray);
        end
        op_x[2] = 16'sh0123;
        op_y[2] = -16'sh0456;
        req_valid = 4'b0100;
        wait_grant(c);
        push_exp(2);
        tick();
        req_valid = '0;
        wait_resp(c);
        e = sb.pop_front();
        tests_run++;
        if (c != 20 || resp_id !== e.id || resp_mag !== e.mag || resp_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rmw_next_job: cyc=%0d id=%0d mag=%h err=%b want 20 %0d %h 0",
                     c, resp_id, resp_mag, resp_err, e.id, e.mag);
        end
        tick();
    endtask

`ifdef CORDIC_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int c;
        int k;
        exp_t e;
        eng_mute = 1'b1;
        req_valid = 4'b0001;
        wait_grant(c);
        e.id = '0;
        e.mag = '0;
        e.err = 1'b1;
        sb.push_back(e);
        exp_ptr = 0;
        tick();
        req_valid = '0;
        tick();
        k = 0;
        while (eng_rst_n === 1'b1 && k < 200) begin
            tick();
            k++;
        end
        tests_run++;
        if (k != 64) begin
            tests_failed++;
            $display("[TB] FAIL tmo_kill_time: got %0d want 64", k);
        end
        tick();
        e = sb.pop_front();
        tests_run++;
        if (eng_rst_n !== 1'b1 || resp_valid !== 1'b1 || resp_id !== e.id ||
            resp_mag !== e.mag || resp_err !== e.err) begin
            tests_failed++;
            $display("[TB] FAIL tmo_resp: rstn=%b rv=%b id=%0d mag=%h err=%b want 1 1 %0d %h %b",
                     eng_rst_n, resp_valid, resp_id, resp_mag, resp_err, e.id, e.mag, e.err);
        end
        tick();
        eng_mute = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) begin
            op_x[i] = '0;
            op_y[i] = '0;
        end
        test_reset();
        test_single_job();
        test_negative();
        test_round_robin();
        test_backpressure();
        test_reset_mid_wait();
`ifdef CORDIC_ARB_TIMEOUT_EN
        test_timeout();
`endif
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL scoreboard_empty: %0d left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
